// File: rtl/regfile_onehot_wr.sv
// 32 x WIDTH register file with a one-hot write-enable vector, hardwired zero register and sticky multi-hot flag.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_onehot_wr #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      wren,
   input  logic [WIDTH-1:0] wrdata,
   input  logic [4:0]       rdaddr1,
   input  logic [4:0]       rdaddr2,
   output logic [WIDTH-1:0] rddata1,
   output logic [WIDTH-1:0] rddata2,
   output logic             wren_err,
   output logic [7:0]       wr_count
);

   localparam int unsigned NREGS  = 32;
   localparam int unsigned AW     = 5;
   localparam int unsigned CNTW   = 8;
   localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);

   logic [WIDTH-1:0] regs [NREGS];
   logic             any_en;
   logic             one_hot;
   logic             multi_hot;
   logic             commit;
   logic [AW-1:0]    wr_idx;

   // Enable classification: a vector is one-hot iff nonzero with no second set bit
   always_comb begin
      any_en    = (wren != 32'd0);
      one_hot   = any_en && ((wren & (wren - 32'd1)) == 32'd0);
      multi_hot = any_en && !one_hot;
      commit    = one_hot && !wren[ZERO_REG];
   end

   // Priority encoder; only meaningful when one_hot
   always_comb begin
      wr_idx = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (wren[i]) wr_idx = AW'(i);
      end
   end

   // Storage, sticky error and saturating commit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         wren_err <= 1'b0;
         wr_count <= '0;
      end else begin
         if (commit) begin
            regs[wr_idx] <= wrdata;
            if (wr_count != {CNTW{1'b1}}) wr_count <= wr_count + CNTW'(1);
         end
         if (multi_hot) wren_err <= 1'b1;
      end
   end

   // Combinational read ports
   always_comb begin
      rddata1 = (rdaddr1 == ZIDX) ? '0 : regs[rdaddr1];
      rddata2 = (rdaddr2 == ZIDX) ? '0 : regs[rdaddr2];
`ifdef REGFILE_BYPASS_EN
      if (commit && !reset && (rdaddr1 == wr_idx)) rddata1 = wrdata;
      if (commit && !reset && (rdaddr2 == wr_idx)) rddata2 = wrdata;
`endif
   end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed self-checking bench for regfile_onehot_wr (either REGFILE_BYPASS_EN build).
module tb_regfile_onehot_wr;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wren;
   logic [63:0] wrdata;
   logic [4:0]  rdaddr1;
   logic [4:0]  rdaddr2;
   logic [63:0] rddata1;
   logic [63:0] rddata2;
   logic        wren_err;
   logic [7:0]  wr_count;

   int n_cmp = 0;
   int n_err = 0;

   regfile_onehot_wr #(.WIDTH(64), .ZERO_REG(31)) dut (
      .clk(clk), .reset(reset), .wren(wren), .wrdata(wrdata),
      .rdaddr1(rdaddr1), .rdaddr2(rdaddr2),
      .rddata1(rddata1), .rddata2(rddata2),
      .wren_err(wren_err), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [63:0] hz_exp;
      reset = 1'b1; wren = '0; wrdata = '0; rdaddr1 = '0; rdaddr2 = '0;
      tick(); tick();
      reset = 1'b0;

      // After reset: every entry reads zero on both ports
      for (int i = 0; i < 32; i++) begin
         rdaddr1 = 5'(i); rdaddr2 = 5'(31 - i);
         #1;
         check("rst_rd1", rddata1, 64'h0);
         check("rst_rd2", rddata2, 64'h0);
      end
      check("rst_err", 64'(wren_err), 64'h0);
      check("rst_cnt", 64'(wr_count), 64'h0);

      // Single write to reg5
      wren = 32'h0000_0020; wrdata = 64'hDEAD_BEEF_0000_0005; rdaddr1 = 5'd5;
      tick();
      wren = '0;
      #1;
      check("wr5_rd1", rddata1, 64'hDEAD_BEEF_0000_0005);
      check("wr5_cnt", 64'(wr_count), 64'd1);

      // Write to XZR discarded
      wren = 32'h8000_0000; wrdata = 64'hFFFF_FFFF_FFFF_FFFF; rdaddr1 = 5'd31; rdaddr2 = 5'd31;
      #1;
      check("xzr_same_rd1", rddata1, 64'h0);
      tick();
      wren = '0;
      #1;
      check("xzr_rd1", rddata1, 64'h0);
      check("xzr_rd2", rddata2, 64'h0);
      check("xzr_err", 64'(wren_err), 64'h0);
      check("xzr_cnt", 64'(wr_count), 64'd1);

      // Multi-hot write is dropped and sets the sticky flag
      wren = 32'h0000_0008; wrdata = 64'h33;
      tick();
      wren = 32'h0000_0018; wrdata = 64'h99; rdaddr1 = 5'd3; rdaddr2 = 5'd4;
      tick();
      wren = '0;
      #1;
      check("mh_reg3", rddata1, 64'h33);
      check("mh_reg4", rddata2, 64'h0);
      check("mh_err", 64'(wren_err), 64'h1);
      check("mh_cnt", 64'(wr_count), 64'd2);
      for (int i = 0; i < 10; i++) tick();
      check("mh_err_held", 64'(wren_err), 64'h1);
      check("mh_reg3_held", rddata1, 64'h33);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("mh_err_clr", 64'(wren_err), 64'h0);
      check("mh_reg3_clr", rddata1, 64'h0);
      check("mh_cnt_clr", 64'(wr_count), 64'd0);

      // Same-cycle hazard on reg2
`ifdef REGFILE_BYPASS_EN
      hz_exp = 64'hABCD;
`else
      hz_exp = 64'h0;
`endif
      wren = 32'h0000_0004; wrdata = 64'hABCD; rdaddr1 = 5'd2; rdaddr2 = 5'd2;
      #1;
      check("hz_same_rd1", rddata1, hz_exp);
      check("hz_same_rd2", rddata2, hz_exp);
      tick();
      wren = '0;
      #1;
      check("hz_next_rd1", rddata1, 64'hABCD);
      check("hz_next_rd2", rddata2, 64'hABCD);

      // Multi-hot including reg2 never forwards and does not overwrite
      wren = 32'h0000_000C; wrdata = 64'h55;
      #1;
      check("mh_nofwd", rddata1, 64'hABCD);
      tick();
      wren = '0;
      #1;
      check("mh_nowr", rddata1, 64'hABCD);
      check("mh2_err", 64'(wren_err), 64'h1);
      check("mh2_cnt", 64'(wr_count), 64'd1);

      // Reset asserted while a write is presented: no forwarding, no write
      reset = 1'b1; wren = 32'h0000_0004; wrdata = 64'h1234;
      #1;
      check("rstwr_nofwd", rddata1, 64'hABCD);
      tick();
      reset = 1'b0; wren = '0;
      #1;
      check("rstwr_rd", rddata1, 64'h0);
      check("rstwr_cnt", 64'(wr_count), 64'd0);

      // Back-to-back writes to regs 0..30
      for (int i = 0; i < 31; i++) begin
         wren = 32'(1) << i; wrdata = 64'h1000 + 64'(i);
         tick();
      end
      wren = '0;
      for (int i = 0; i < 31; i++) begin
         rdaddr1 = 5'(i); rdaddr2 = 5'(30 - i);
         #1;
         check("b2b_rd1", rddata1, 64'h1000 + 64'(i));
         check("b2b_rd2", rddata2, 64'h1000 + 64'(30 - i));
      end
      check("b2b_cnt", 64'(wr_count), 64'd31);

      // Counter saturation
      for (int k = 0; k < 224; k++) begin
         wren = 32'(1) << (k % 31); wrdata = 64'(k);
         tick();
      end
      wren = '0;
      #1;
      check("sat_255", 64'(wr_count), 64'd255);
      for (int k = 0; k < 76; k++) begin
         wren = 32'(1) << (k % 31); wrdata = 64'(k);
         tick();
      end
      wren = '0;
      #1;
      check("sat_hold", 64'(wr_count), 64'd255);

      // Reset concurrent with write to reg7
      rdaddr1 = 5'd7;
      wren = 32'h0000_0080; wrdata = 64'h77; reset = 1'b1;
      tick();
      reset = 1'b0; wren = '0;
      #1;
      check("rst7_rd", rddata1, 64'h0);
      check("rst7_cnt", 64'(wr_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
